// File: rtl/fifo_stream_reader.sv
// Pulls words from a synchronous FIFO through a 3-entry skid buffer and presents
// them as a ready/valid stream with PKT_LEN-beat packet framing and a running beat count.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [15:0]           beat_count
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] BCNT_MAX = BW'(PKT_LEN - 1);

   logic                  r_run;
   logic                  r_inflight;
   logic [1:0]            r_occ;
   logic [1:0]            r_wr_ptr;
   logic [1:0]            r_rd_ptr;
   logic [BW-1:0]         r_bcnt;
   logic [15:0]           r_beat_count;
   logic [DATA_WIDTH-1:0] r_mem [0:2];

   logic       w_xfer;
   logic [2:0] w_pending;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Reads are credited against words already buffered plus the one in flight,
   // so a full buffer can never be overrun regardless of m_ready.
   assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
   assign fifo_rd_en = r_run & en & ~fifo_empty & (w_pending < 3'd3);

   assign m_valid    = (r_occ != 2'd0);
   assign m_data     = m_valid ? r_mem[r_rd_ptr] : '0;
   assign m_last     = m_valid & (r_bcnt == BCNT_MAX);
   assign beat_count = r_beat_count;
   assign w_xfer     = m_valid & m_ready;

   always_ff @(posedge clk) begin
      if (r_inflight) r_mem[r_wr_ptr] <= fifo_data;
   end

   // r_run holds off reads until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run        <= 1'b0;
         r_inflight   <= 1'b0;
         r_occ        <= 2'd0;
         r_wr_ptr     <= 2'd0;
         r_rd_ptr     <= 2'd0;
         r_bcnt       <= '0;
         r_beat_count <= 16'd0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= fifo_rd_en;
         if (r_inflight) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_xfer) begin
            r_rd_ptr     <= ptr_inc(r_rd_ptr);
            r_beat_count <= r_beat_count + 16'd1;
            r_bcnt       <= (r_bcnt == BCNT_MAX) ? '0 : r_bcnt + BW'(1);
         end
         case ({r_inflight, w_xfer})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural synchronous FIFO upstream.
module tb_fifo_stream_reader;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;
   logic [15:0] beat_count;

   int tests = 0;
   int fails = 0;

   logic [7:0] fmem [0:255];
   int fhead = 0;
   int ftail = 0;

   fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .beat_count (beat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (fhead == ftail);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= fmem[8'(fhead)];
         fhead     <= fhead + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      fmem[8'(ftail)] = v;
      ftail = ftail + 1;
   endtask

   task automatic do_reset();
      en      = 1'b0;
      m_ready = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int h0, reads, bad, got, n, lastbad;
      fifo_data = 8'h00;
      rst_n     = 1'b0;
      en        = 1'b0;
      m_ready   = 1'b0;
      #1;
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_data", 32'(m_data), 32'd0);
      check("reset_bcount", 32'(beat_count), 32'd0);
      check("reset_rd_en", 32'(fifo_rd_en), 32'd0);

      // streaming 0x10..0x17
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      en = 1'b1;
      m_ready = 1'b1;
      #1 check("stream_first_rd", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      check("stream_latency_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check("stream_valid", 32'(m_valid), 32'd1);
         check("stream_data", 32'(m_data), 32'(8'h10 + i));
         check("stream_last", 32'(m_last), 32'((i % 4) == 3));
         check("stream_bcount", 32'(beat_count), 32'(i));
         @(negedge clk);
      end
      check("stream_done_valid", 32'(m_valid), 32'd0);
      check("stream_total", 32'(beat_count), 32'd8);

      // backpressure with 6 words
      do_reset();
      for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
      h0 = fhead;
      en = 1'b1;
      reads = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (fifo_rd_en) reads++;
         if (m_valid && m_data !== 8'h20) bad++;
         @(negedge clk);
      end
      check("bp_reads", 32'(reads), 32'd3);
      check("bp_popped", 32'(fhead - h0), 32'd3);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data", 32'(m_data), 32'h20);
      check("bp_stable", 32'(bad), 32'd0);
      m_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         if (m_valid) begin
            check("bp_drain_data", 32'(m_data), 32'(8'h20 + got));
            got++;
         end
         @(negedge clk);
      end
      check("bp_drain_count", 32'(got), 32'd6);
      check("bp_bcount", 32'(beat_count), 32'd6);

      // empty boundary then single word 0xA5
      do_reset();
      en = 1'b1;
      m_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (fifo_rd_en || m_valid) bad++;
         @(negedge clk);
      end
      check("empty_idle", 32'(bad), 32'd0);
      push(8'hA5);
      #1 check("empty_rd_after_push", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      check("empty_latency_valid", 32'(m_valid), 32'd0);
      @(negedge clk);
      check("empty_a5_valid", 32'(m_valid), 32'd1);
      check("empty_a5_data", 32'(m_data), 32'hA5);
      @(negedge clk);

      // en drop right after a read
      en = 1'b0;
      push(8'h30);
      push(8'h31);
      push(8'h32);
      h0 = fhead;
      en = 1'b1;
      #1 check("endrop_rd", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      en = 1'b0;
      #1 check("endrop_no_rd", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      check("endrop_inflight_valid", 32'(m_valid), 32'd1);
      check("endrop_inflight_data", 32'(m_data), 32'h30);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (fifo_rd_en || m_valid) bad++;
         @(negedge clk);
      end
      check("endrop_quiet", 32'(bad), 32'd0);
      check("endrop_popped", 32'(fhead - h0), 32'd1);
      en = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         if (m_valid) begin
            check("endrop_resume_data", 32'(m_data), 32'(8'h31 + got));
            got++;
         end
         @(negedge clk);
      end
      check("endrop_resume_count", 32'(got), 32'd2);
      @(negedge clk);
      @(negedge clk);

      // async reset mid-stream with two words buffered
      for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
      m_ready = 1'b0;
      en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("ar_head_data", 32'(m_data), 32'h40);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("ar_pre_data", 32'(m_data), 32'h41);
      check("ar_pre_bcount", 32'(beat_count), 32'd5);
      check("ar_pre_last", 32'(m_last), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(m_valid), 32'd0);
      check("ar_data", 32'(m_data), 32'd0);
      check("ar_last", 32'(m_last), 32'd0);
      check("ar_bcount", 32'(beat_count), 32'd0);
      check("ar_rd_en", 32'(fifo_rd_en), 32'd0);
      @(posedge clk);
      #1 check("ar_rd_en_held", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ready = 1'b1;
      #1 check("ar_no_early_rd", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      #1 check("ar_first_rd", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("ar_restart_valid", 32'(m_valid), 32'd1);
      check("ar_restart_data", 32'(m_data), 32'h43);
      check("ar_restart_last", 32'(m_last), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check("ar_stream_data", 32'(m_data), 32'(8'h43 + k));
         check("ar_stream_last", 32'(m_last), 32'(k == 3));
      end
      check("ar_stream_bcount", 32'(beat_count), 32'd3);

      // beat_count wrap over 65537 transfers
      do_reset();
      ftail = fhead + 65537;
      en = 1'b1;
      m_ready = 1'b1;
      n = 0;
      lastbad = 0;
      for (int c = 0; c < 66000 && n < 65537; c++) begin
         if (m_valid) begin
            if (m_last !== ((n % 4) == 3)) lastbad++;
            n++;
         end
         @(negedge clk);
      end
      check("wrap_transfers", 32'(n), 32'd65537);
      check("wrap_last_pattern", 32'(lastbad), 32'd0);
      check("wrap_bcount", 32'(beat_count), 32'd1);
      check("wrap_drained", 32'(m_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
